// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack memory handshake
// with a timeout, and holds each instruction for decode until it is accepted.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 16
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        PC_sel,
   input  logic [31:0] Immed_PC,
   output logic        Mem_req,
   output logic [31:0] Mem_addr,
   input  logic        Mem_ack,
   input  logic [31:0] Mem_rdata,
   output logic [31:0] Instr,
   output logic        Instr_valid,
   input  logic        Instr_accept,
   output logic [31:0] PC,
   output logic [31:0] PC_plus4,
   output logic        Mem_err
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic [31:0] branch_off;
   logic [31:0] next_pc;

   assign Mem_addr   = PC;
   assign PC_plus4   = PC + 32'd4;
   // Offset is in words; the top two bits fall off the shift.
   assign branch_off = {Immed_PC[29:0], 2'b00};
   assign next_pc    = PC_sel ? (PC_plus4 + branch_off) : PC_plus4;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= S_REQ;
         PC          <= {RESET_PC[31:2], 2'b00};
         Mem_req     <= 1'b0;
         Instr       <= 32'h0000_0000;
         Instr_valid <= 1'b0;
         Mem_err     <= 1'b0;
         cnt         <= 8'd0;
      end else begin
         case (state)
            S_REQ: begin
               Mem_req <= 1'b1;
               cnt     <= 8'd0;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               cnt <= cnt + 8'd1;
               // Ack takes priority over a timeout landing in the same cycle.
               if (Mem_ack) begin
                  Instr       <= Mem_rdata;
                  Instr_valid <= 1'b1;
                  Mem_req     <= 1'b0;
                  state       <= S_HOLD;
               end else if (cnt == CNT_LAST) begin
                  Instr       <= 32'h0000_0000;
                  Instr_valid <= 1'b1;
                  Mem_err     <= 1'b1;
                  Mem_req     <= 1'b0;
                  state       <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (Instr_valid && Instr_accept) begin
                  Instr_valid <= 1'b0;
                  PC          <= {next_pc[31:2], 2'b00};
                  // Raise the request now so the new PC goes out next cycle.
                  Mem_req     <= 1'b1;
                  state       <= S_REQ;
               end
            end
            default: state <= S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential/branch next-PC, hold stability,
// timeout behaviour, async reset mid-fetch and address wrap-around.
module tb_pc_fetch_unit;

   logic        Clk;
   logic        Reset_n;
   logic        PC_sel;
   logic [31:0] Immed_PC;
   logic        Mem_req;
   logic [31:0] Mem_addr;
   logic        Mem_ack;
   logic [31:0] Mem_rdata;
   logic [31:0] Instr;
   logic        Instr_valid;
   logic        Instr_accept;
   logic [31:0] PC;
   logic [31:0] PC_plus4;
   logic        Mem_err;

   int n_cmp = 0;
   int n_err = 0;

   pc_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .PC_sel(PC_sel), .Immed_PC(Immed_PC),
      .Mem_req(Mem_req), .Mem_addr(Mem_addr), .Mem_ack(Mem_ack),
      .Mem_rdata(Mem_rdata), .Instr(Instr), .Instr_valid(Instr_valid),
      .Instr_accept(Instr_accept), .PC(PC), .PC_plus4(PC_plus4),
      .Mem_err(Mem_err)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Starts from S_REQ: first step lands in the first S_WAIT cycle.
   task automatic fetch(input int waits, input logic [31:0] rdata, input logic [31:0] exp_pc);
      step();
      chk("req_in_wait", Mem_req, 1);
      chk("addr_in_wait", Mem_addr, exp_pc);
      chk("valid_in_wait", Instr_valid, 0);
      Mem_ack = 1'b0;
      repeat (waits) step();
      Mem_ack   = 1'b1;
      Mem_rdata = rdata;
      step();
      Mem_ack   = 1'b0;
      Mem_rdata = 32'hDEAD_BEEF;
      chk("instr", Instr, rdata);
      chk("valid_after_ack", Instr_valid, 1);
      chk("req_after_ack", Mem_req, 0);
      chk("pc_held", PC, exp_pc);
   endtask

   task automatic accept(input logic sel, input logic [31:0] imm, input logic [31:0] exp_pc);
      Instr_accept = 1'b1;
      PC_sel       = sel;
      Immed_PC     = imm;
      step();
      Instr_accept = 1'b0;
      PC_sel       = 1'b0;
      Immed_PC     = 32'h0;
      chk("valid_after_acc", Instr_valid, 0);
      chk("req_after_acc", Mem_req, 1);
      chk("next_addr", Mem_addr, exp_pc);
   endtask

   initial begin
      Reset_n = 1'b0; PC_sel = 1'b0; Immed_PC = 32'h0; Mem_ack = 1'b0;
      Mem_rdata = 32'h0; Instr_accept = 1'b0;
      step(); step();
      chk("rst_pc", PC, 32'h0);
      chk("rst_addr", Mem_addr, 32'h0);
      chk("rst_pc4", PC_plus4, 32'h4);
      chk("rst_req", Mem_req, 0);
      chk("rst_instr", Instr, 32'h0);
      chk("rst_valid", Instr_valid, 0);
      chk("rst_err", Mem_err, 0);
      Reset_n = 1'b1;

      // Basic fetch with 2 wait cycles, then sequential advance.
      fetch(2, 32'h1234_5678, 32'h0);
      accept(1'b0, 32'h0, 32'h4);
      fetch(0, 32'hAAAA_0001, 32'h4);
      accept(1'b1, 32'd14, 32'h40);       // 4+4+56
      fetch(1, 32'hBBBB_0002, 32'h40);

      // Hold with no accept: everything frozen, PC_sel toggling ignored.
      for (int i = 0; i < 5; i++) begin
         PC_sel   = i[0];
         Immed_PC = 32'h100 * i;
         step();
         chk("hold_instr", Instr, 32'hBBBB_0002);
         chk("hold_pc", PC, 32'h40);
         chk("hold_valid", Instr_valid, 1);
         chk("hold_req", Mem_req, 0);
      end
      accept(1'b1, 32'h0000_0003, 32'h50);
      fetch(0, 32'hCCCC_0003, 32'h50);
      accept(1'b1, 32'hFFFF_FFFB, 32'h40);  // 0x54-20
      fetch(0, 32'hCCCC_0004, 32'h40);
      accept(1'b1, 32'hFFFF_FFFE, 32'h3C);  // 0x44-8
      fetch(0, 32'hCCCC_0005, 32'h3C);
      accept(1'b1, 32'hFFFF_FFEF, 32'hFFFF_FFFC);  // 0x40-68
      chk("pc4_wrap", PC_plus4, 32'h0);
      fetch(0, 32'hCCCC_0006, 32'hFFFF_FFFC);

      // Spurious ack in hold is ignored.
      Mem_ack = 1'b1; Mem_rdata = 32'h5555_5555;
      step();
      Mem_ack = 1'b0;
      chk("spurious_instr", Instr, 32'hCCCC_0006);
      chk("spurious_valid", Instr_valid, 1);
      accept(1'b0, 32'h0, 32'h0);

      // Timeout: no ack for 16 S_WAIT cycles.
      step();
      Mem_ack = 1'b0;
      repeat (15) step();
      chk("pre_to_valid", Instr_valid, 0);
      chk("pre_to_err", Mem_err, 0);
      step();
      chk("to_instr", Instr, 32'h0);
      chk("to_valid", Instr_valid, 1);
      chk("to_err", Mem_err, 1);
      chk("to_req", Mem_req, 0);
      accept(1'b0, 32'h0, 32'h4);
      fetch(3, 32'hDDDD_0007, 32'h4);
      chk("err_sticky", Mem_err, 1);

      // Reset clears the error; ack exactly on the timeout cycle wins.
      Reset_n = 1'b0;
      #1;
      chk("rst2_err", Mem_err, 0);
      step();
      Reset_n = 1'b1;
      fetch(15, 32'hEEEE_0008, 32'h0);
      chk("edge_ack_err", Mem_err, 0);
      accept(1'b1, 32'h4000_0001, 32'h8);   // top bits discarded: 0+4+4
      fetch(0, 32'hEEEE_0009, 32'h8);
      accept(1'b1, 32'h0000_001D, 32'h80);  // 0xC+0x74

      // Async reset while in S_WAIT at 0x80; stale ack afterwards is ignored.
      step();
      step();
      chk("wait_addr_80", Mem_addr, 32'h80);
      #2 Reset_n = 1'b0;
      #1;
      chk("async_pc", PC, 32'h0);
      chk("async_req", Mem_req, 0);
      chk("async_valid", Instr_valid, 0);
      Mem_ack = 1'b1; Mem_rdata = 32'h7777_7777;
      step();
      Reset_n = 1'b1;
      fetch(1, 32'hFFFF_000A, 32'h0);
      chk("post_rst_err", Mem_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage of the processor. It holds the program counter and computes next-PC from the branch offset supplied by the immediate selector.
- It fetches each instruction from a variable-latency instruction memory over a req/ack handshake, then presents the instruction to decode with a valid/accept handshake.
- It sits directly downstream of the immediate selector's PC-offset output and upstream of the decode/register-file stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, max cycles to wait for Mem_ack before abandoning a fetch (range 2..255).

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset_n  in  1  asynchronous active-low reset
- PC_sel  in  1  1 = take branch on the current advance, 0 = sequential
- Immed_PC  in  32  sign-extended branch offset in words, from the immediate selector
- Mem_req  out  1  fetch request to instruction memory
- Mem_addr  out  32  byte address of the fetch; equals PC
- Mem_ack  in  1  one-cycle pulse, Mem_rdata valid in the same cycle
- Mem_rdata  in  32  instruction word from memory
- Instr  out  32  fetched instruction
- Instr_valid  out  1  Instr is valid and held stable
- Instr_accept  in  1  decode consumes Instr this cycle
- PC  out  32  address of the instruction currently fetched or held
- PC_plus4  out  32  PC + 4, combinational
- Mem_err  out  1  sticky flag: a fetch timed out

Behaviour:
- Reset (asynchronous, Reset_n = 0): PC = RESET_PC, state = S_REQ, Mem_req = 0, Instr = 0, Instr_valid = 0, Mem_err = 0, timeout counter = 0. Reset asserted mid-fetch or mid-hold abandons everything; a late Mem_ack after reset release is ignored unless in S_WAIT.
- Address: Mem_addr = PC at all times. PC[1:0] is always 00.
- State S_REQ: Mem_req = 1 for one cycle, counter cleared, go to S_WAIT.
- State S_WAIT: Mem_req stays 1, counter increments each cycle.
  - Mem_ack = 1: Instr <= Mem_rdata, Instr_valid <= 1, Mem_req <= 0, go to S_HOLD.
  - Counter reaches TIMEOUT-1 with no ack: Instr <= 32'h0000_0000 (NOP), Instr_valid <= 1, Mem_err <= 1, go to S_HOLD.
  - Ack in the same cycle as timeout: ack wins, Mem_err unchanged.
- State S_HOLD: Instr and PC held stable while Instr_valid = 1.
  - On Instr_valid && Instr_accept: Instr_valid <= 0 and PC is updated at that edge, then go to S_REQ.
  - Next PC when PC_sel = 0: PC + 4.
  - Next PC when PC_sel = 1: PC + 4 + (Immed_PC << 2).
  - PC_sel and Immed_PC are sampled only in the accept cycle and ignored otherwise.
- Latency: ack in cycle N gives Instr_valid = 1 in cycle N+1. Accept in cycle M gives Mem_req = 1 with the new PC in cycle M+1. Best-case throughput is one instruction per 3 cycles with zero-wait memory.
- Mem_ack outside S_WAIT is ignored.
- Arithmetic: 32-bit unsigned, modulo 2^32; Immed_PC << 2 discards bits 31:30. Wrap-around is permitted without a flag, e.g. PC 32'hFFFF_FFFC + 4 gives 0.
- Mem_err clears only on reset.

Test Plan:
- Reset release with RESET_PC = 0 and ack after 2 wait cycles, rdata 32'h1234_5678 -> Mem_addr 0; Instr 32'h1234_5678 valid; after accept with PC_sel = 0, next Mem_addr = 4.
- At PC = 32'h40, accept with PC_sel = 1, Immed_PC = 32'h0000_0003 -> next Mem_addr = 32'h50. Repeat at PC = 32'h40 with Immed_PC = 32'hFFFF_FFFE -> next Mem_addr = 32'h3C.
- Instr_accept held 0 for 5 cycles while Instr_valid = 1 -> Instr, PC and Instr_valid unchanged, Mem_req stays 0; PC_sel toggling during the hold has no effect.
- No ack with TIMEOUT = 16 -> Instr = 0, Instr_valid = 1, Mem_err = 1 after 16 cycles in S_WAIT. Mem_err stays 1 across later successful fetches; ack arriving on the exact timeout cycle returns rdata with Mem_err = 0.
- Reset_n pulsed low while in S_WAIT at PC = 32'h80 -> outputs immediately return to reset values; the stale Mem_ack is ignored; refetch starts at RESET_PC.
- PC = 32'hFFFF_FFFC, accept with PC_sel = 0 -> next Mem_addr = 32'h0000_0000; spurious Mem_ack in S_HOLD leaves Instr unchanged.
